logo_delt_ctrl: RTL and testbench
=================================

# logo_delt_ctrl

Frame-synchronous horizontal offset generator for the VGA logo layer. It counts vertical-sync frames and produces the 11-bit `delt` offset consumed by the `paintLogo*` hit-test blocks. It changes `delt` only at a frame boundary, so every logo letter moves together with no tearing. It sits between the VGA sync generator (source of `vsync`) and the logo painters (sinks of `delt`).

## Interface
- `DELT_MAX`, 200: largest offset value; `delt` stays in 0..DELT_MAX. Legal range is 1..2047.
- `STEP`, 2: pixels moved per step. Legal range is 1..DELT_MAX.
- `FRAME_DIV`, 2: number of frame ticks per step. Legal range is 1..255.
- `VSYNC_POL`, 0: active level of `vsync`. 0 means active-low.
- `clk` in 1: pixel/system clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `enble` in 1: motion enable. When low, the block is held at its home position.
- `vsync` in 1: vertical sync from the VGA timing generator, on the `clk` domain.
- `pause` in 1: freezes motion while high. Position and phase are retained.
- `delt` out 11: horizontal offset for the logo painters.
- `dir` out 1: current direction. 0 = increasing, 1 = decreasing.
- `step_pulse` out 1: one-cycle strobe, high in the cycle `delt` takes a new value.

## Operation
- `vs_q` register holds the previous sample of `vsync`.
  - Frame tick `tick` = `vsync` at its active level AND `vs_q` at its inactive level.
  - Only the inactive-to-active transition counts.
- Frame counter `fcnt` is 8 bits.
  - On `tick` with `pause`=0: if `fcnt`==FRAME_DIV-1, a step occurs and `fcnt` returns to 0; otherwise `fcnt` increments.
  - On `tick` with `pause`=1: `fcnt`, `delt` and `dir` all hold.
- State machine has three states: HOME, RIGHT, LEFT. `dir` = 1 only in LEFT.
  - HOME: `delt`=0, `fcnt`=0. Moves to RIGHT on the first cycle `enble`=1. No step is taken in the transition cycle.
  - RIGHT step: compute `delt`+STEP in 12 bits. If the sum ≥ DELT_MAX, `delt` becomes DELT_MAX and the state goes to LEFT; otherwise `delt` becomes the sum.
  - LEFT step: if `delt` ≤ STEP, `delt` becomes 0 and the state goes to RIGHT; otherwise `delt` is decremented by STEP.
  - `enble`=0 in any state: next state is HOME with `delt`=0, `fcnt`=0, `dir`=0. This takes priority over `tick` and `pause`.
- Arithmetic uses a 12-bit intermediate, so `delt` never overflows or underflows 11 bits.
- `step_pulse` is 1 exactly on the cycles where a step was applied. This includes steps that clamp to 0 or DELT_MAX.

## Timing
- Reset values:
  - `delt`=0, `dir`=0, `step_pulse`=0, state HOME, `fcnt`=0.
  - `vs_q` = active level (`~VSYNC_POL` inverted accordingly). This prevents a spurious tick when reset is released while `vsync` is already active.
- Latency: `vsync` is first sampled active at edge N, with `vs_q` inactive. When a step is due, `delt` and `step_pulse` are updated at edge N. They are visible from N to N+1.
- `step_pulse` is high for exactly one cycle per step. Holding `vsync` active for many cycles produces only one tick.
- `rst` asserted mid-frame or mid-step: at the next edge all registers take their reset values and no step occurs. `rst` has priority over `enble`.
- `pause` and `tick` in the same cycle: no step occurs, and `fcnt` does not advance.
- `enble` falling edge in the same cycle as a due step: HOME wins, `delt`=0, and `step_pulse`=0.
- If `vsync` has a glitch of at least one sample, it counts as a frame. Filtering is the sync generator's job.

## Configuration
- `LOGO_DELT_WRAP_EN` defined:
  - The LEFT state is removed and `dir` is tied to 0.
  - RIGHT step: if `delt`+STEP > DELT_MAX, `delt` becomes `delt`+STEP−DELT_MAX−1, i.e. the result is modulo DELT_MAX+1. Otherwise `delt` becomes the sum.
- `LOGO_DELT_WRAP_EN` undefined: ping-pong bounce as described in Operation. This is the default build.

## Test plan
- Reset with `vsync` held active, then release. No `step_pulse` occurs until `vsync` goes inactive and then active again. `delt` stays 0.
- Defaults, `enble`=1, 4 vsync pulses → `delt` sequence 0,0,2,2,4. `step_pulse` fires on the 2nd and 4th ticks only.
- DELT_MAX=5, STEP=2, FRAME_DIV=1, 8 ticks → `delt` 2,4,5 (dir→1),3,1,0 (dir→0),2,4.
- `pause`=1 across 3 ticks at `delt`=4 with `fcnt`=1. `delt` stays 4. After release, the very next tick steps to 6.
- `enble` deasserted on the same cycle as a due tick → `delt`=0, `dir`=0, `step_pulse`=0. Re-enable, then 2 ticks → `delt`=2.
- `LOGO_DELT_WRAP_EN` build, DELT_MAX=5, STEP=2, FRAME_DIV=1 → `delt` 2,4,0,2,4,0. `dir` stays 0.

Source files
------------

// File: rtl/logo_delt_ctrl.sv
// logo_delt_ctrl: frame-synchronous horizontal offset generator for the VGA
// logo layer. It counts vsync frame ticks and moves the 11-bit `delt` offset
// by STEP pixels every FRAME_DIV frames. Because `delt` only changes on a frame
// tick, every logo letter moves together.
//
// Build option: define LOGO_DELT_WRAP_EN to replace the ping-pong bounce with
// a modulo (DELT_MAX+1) wrap. In that build the LEFT state does not exist and
// `dir` is always 0. Without the macro the offset bounces between 0 and
// DELT_MAX.
//
// Handshake note: there is no valid/ready handshake here. `step_pulse` is a
// single-cycle strobe that is high in exactly the cycle `delt` holds a freshly
// stepped value, including steps that clamp to 0 or DELT_MAX.

module logo_delt_ctrl #(
  parameter int DELT_MAX  = 200,  // 1..2047
  parameter int STEP      = 2,    // 1..DELT_MAX
  parameter int FRAME_DIV = 2,    // 1..255
  parameter bit VSYNC_POL = 1'b0  // active level of vsync (0 = active-low)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enble,
  input  logic        vsync,
  input  logic        pause,
  output logic [10:0] delt,
  output logic        dir,
  output logic        step_pulse
);

  // Constants sized to the datapath so that every comparison has matching widths.
  localparam logic       VS_ACT   = VSYNC_POL;
  localparam logic [10:0] MAX_N   = 11'(DELT_MAX);
  localparam logic [10:0] STEP_N  = 11'(STEP);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

`ifdef LOGO_DELT_WRAP_EN
  typedef enum logic [1:0] {
    HOME  = 2'd0,
    RIGHT = 2'd1
  } state_t;
`else
  typedef enum logic [1:0] {
    HOME  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } state_t;
`endif

  state_t      state;
  state_t      nxt_state;
  logic        vs_q;
  logic [7:0]  fcnt;
  logic        tick;
  logic        moving;
  logic [11:0] sum;
  logic [10:0] nxt_delt;
  logic        nxt_dir;

  // A frame tick is only the inactive-to-active edge of vsync.
  assign tick = (vsync == VS_ACT) && (vs_q != VS_ACT);

  // Ticks are only counted once the block has left HOME.
  assign moving = (state != HOME);

  // The 12-bit sum keeps a carry, so an overflow past 2047 can never alias
  // to a small offset.
  assign sum = {1'b0, delt} + {1'b0, STEP_N};

  // Compute the position, direction and state that the next step would produce.
  always_comb begin
    nxt_delt  = delt;
    nxt_dir   = dir;
    nxt_state = state;
    case (state)
      RIGHT: begin
`ifdef LOGO_DELT_WRAP_EN
        nxt_dir = 1'b0;
        if (sum > {1'b0, MAX_N}) begin
          // The result is below DELT_MAX, so 11-bit modular arithmetic is exact.
          nxt_delt = delt + STEP_N - MAX_N - 11'd1;
        end else begin
          nxt_delt = sum[10:0];
        end
`else
        if (sum >= {1'b0, MAX_N}) begin
          nxt_delt  = MAX_N;
          nxt_dir   = 1'b1;
          nxt_state = LEFT;
        end else begin
          nxt_delt = sum[10:0];
        end
`endif
      end
`ifndef LOGO_DELT_WRAP_EN
      LEFT: begin
        if (delt <= STEP_N) begin
          nxt_delt  = 11'd0;
          nxt_dir   = 1'b0;
          nxt_state = RIGHT;
        end else begin
          nxt_delt = delt - STEP_N;
        end
      end
`endif
      default: begin
        nxt_delt  = delt;
        nxt_dir   = dir;
        nxt_state = state;
      end
    endcase
  end

  // Sample vsync for edge detection. The reset value is the active level, so
  // releasing reset while vsync is already active does not produce a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= VS_ACT;
    end else begin
      vs_q <= vsync;
    end
  end

  // Motion FSM with registered outputs. Reset beats enable, enable beats tick
  // and pause, and pause freezes the frame counter together with the position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOME;
      fcnt       <= 8'd0;
      delt       <= 11'd0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
    end else if (!enble) begin
      state      <= HOME;
      fcnt       <= 8'd0;
      delt       <= 11'd0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        HOME: begin
          // Leaving HOME never steps, even if a tick lands in this cycle.
          state <= RIGHT;
          fcnt  <= 8'd0;
          delt  <= 11'd0;
          dir   <= 1'b0;
        end
        default: begin
          if (moving && tick && !pause) begin
            if (fcnt == DIV_LAST) begin
              fcnt       <= 8'd0;
              delt       <= nxt_delt;
              dir        <= nxt_dir;
              state      <= nxt_state;
              step_pulse <= 1'b1;
            end else begin
              fcnt <= fcnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logo_delt_ctrl.sv
// Directed bench for logo_delt_ctrl. Instance A uses the default parameters;
// instance B uses DELT_MAX=5, STEP=2, FRAME_DIV=1 to reach both ends of the
// travel quickly. Expectations follow LOGO_DELT_WRAP_EN when it is defined.

module tb_logo_delt_ctrl;

  logic        clk;
  logic        rst;
  logic        en_a, vs_a, pa_a;
  logic        en_b, vs_b, pa_b;
  logic [10:0] delt_a, delt_b;
  logic        dir_a, dir_b;
  logic        sp_a, sp_b;

  int n_checks;
  int n_fail;

  logo_delt_ctrl u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .enble      (en_a),
    .vsync      (vs_a),
    .pause      (pa_a),
    .delt       (delt_a),
    .dir        (dir_a),
    .step_pulse (sp_a)
  );

  logo_delt_ctrl #(
    .DELT_MAX  (5),
    .STEP      (2),
    .FRAME_DIV (1),
    .VSYNC_POL (1'b0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .enble      (en_b),
    .vsync      (vs_b),
    .pause      (pa_b),
    .delt       (delt_b),
    .dir        (dir_b),
    .step_pulse (sp_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One vsync pulse (active-low) held for `low` cycles. sp_first is the strobe
  // in the cycle after the tick edge; sp_extra flags any strobe afterwards.
  task automatic pulse(input int which, input int low,
                       output logic sp_first, output logic sp_extra);
    sp_extra = 1'b0;
    @(negedge clk);
    if (which == 0) vs_a = 1'b0; else vs_b = 1'b0;
    @(negedge clk);
    sp_first = (which == 0) ? sp_a : sp_b;
    for (int i = 1; i < low; i++) begin
      @(negedge clk);
      if (((which == 0) ? sp_a : sp_b) == 1'b1) sp_extra = 1'b1;
    end
    if (which == 0) vs_a = 1'b1; else vs_b = 1'b1;
  endtask

  int   exp_delt_b [8];
  logic exp_dir_b  [8];
  logic spf, spx;
  logic any_sp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef LOGO_DELT_WRAP_EN
    exp_delt_b = '{2, 4, 0, 2, 4, 0, 2, 4};
    exp_dir_b  = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_delt_b = '{2, 4, 5, 3, 1, 0, 2, 4};
    exp_dir_b  = '{0, 0, 1, 1, 1, 0, 0, 0};
`endif

    // Reset with A's vsync held active.
    rst  = 1'b1;
    en_a = 1'b1; vs_a = 1'b0; pa_a = 1'b0;
    en_b = 1'b1; vs_b = 1'b1; pa_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_delt_a", delt_a, 0);
    check("rst_dir_a",  dir_a,  0);
    check("rst_sp_a",   sp_a,   0);
    check("rst_delt_b", delt_b, 0);
    rst = 1'b0;

    // vsync still active after release: no tick may appear.
    any_sp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sp_a) any_sp = 1'b1;
    end
    check("held_vs_no_sp", any_sp, 0);
    check("held_vs_delt",  delt_a, 0);
    vs_a = 1'b1;
    repeat (2) @(negedge clk);

    // Default parameters, 4 pulses: delt 0,2,2,4, strobe on 2nd and 4th.
    pulse(0, 1, spf, spx);
    check("t1_delt", delt_a, 0);  check("t1_sp", spf, 0);
    pulse(0, 1, spf, spx);
    check("t2_delt", delt_a, 2);  check("t2_sp", spf, 1);
    pulse(0, 1, spf, spx);
    check("t3_delt", delt_a, 2);  check("t3_sp", spf, 0);
    pulse(0, 5, spf, spx);
    check("t4_delt", delt_a, 4);  check("t4_sp", spf, 1);
    check("t4_long_vs_one_sp", spx, 0);

    // fcnt -> 1 at delt 4, then pause across 3 ticks.
    pulse(0, 1, spf, spx);
    check("t5_delt", delt_a, 4);  check("t5_sp", spf, 0);
    pa_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1, spf, spx);
      check("pause_delt", delt_a, 4);
      check("pause_sp",   spf,    0);
    end
    @(negedge clk);
    pa_a = 1'b0;
    pulse(0, 1, spf, spx);
    check("unpause_delt", delt_a, 6);  check("unpause_sp", spf, 1);

    // Make a step due, then drop enable in the tick cycle.
    pulse(0, 1, spf, spx);
    check("pre_en_delt", delt_a, 6);
    @(negedge clk);
    vs_a = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    check("en_off_delt", delt_a, 0);
    check("en_off_dir",  dir_a,  0);
    check("en_off_sp",   sp_a,   0);
    vs_a = 1'b1;
    @(negedge clk);
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    pulse(0, 1, spf, spx);
    check("reen_t1_delt", delt_a, 0);
    pulse(0, 1, spf, spx);
    check("reen_t2_delt", delt_a, 2);  check("reen_t2_sp", spf, 1);

    // Small instance: every tick steps, covering both clamps.
    for (int i = 0; i < 8; i++) begin
      pulse(1, 1, spf, spx);
      check($sformatf("b_delt_%0d", i), delt_b, exp_delt_b[i]);
      check($sformatf("b_dir_%0d", i),  dir_b,  exp_dir_b[i]);
      check($sformatf("b_sp_%0d", i),   spf,    1);
    end

    // Reset coinciding with a due tick: no step, reset values.
    @(negedge clk);
    vs_b = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("rst_mid_delt", delt_b, 0);
    check("rst_mid_dir",  dir_b,  0);
    check("rst_mid_sp",   sp_b,   0);
    vs_b = 1'b1;
    rst  = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
